// File: rtl/thread_status_tracker_pkg.sv
// rtl/thread_status_tracker_pkg.sv - shared types and defaults for thread status tracking
package thread_status_tracker_pkg;

  localparam int n_threads             = 8;
  localparam int STALL_TIMEOUT_DEFAULT = 1024;

  typedef logic [$clog2(n_threads)-1:0] threadid_t;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_ILLEGAL = 2'd1,
    EXC_MEM     = 2'd2,
    EXC_TIMEOUT = 2'd3
  } exc_cause_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    EXC_PEND = 2'd2
  } thread_state_t;

endpackage

// File: rtl/thread_status_tracker_rr_arbiter.sv
// rtl/thread_status_tracker_rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after ptr wins;
  // k=N aliases to ptr itself, giving the pointer holder lowest priority.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N; k >= 1; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_status_tracker.sv
// rtl/thread_status_tracker.sv - per-thread RUN/STALL/EXC_PEND tracker with watchdog and redirect arbitration
module thread_status_tracker
  import thread_status_tracker_pkg::*;
#(
  parameter int N_THREADS     = n_threads,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEFAULT,
  parameter int TO_W          = $clog2(STALL_TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_en,
  input  threadid_t            stall_thread,
  input  logic                 wake_en,
  input  threadid_t            wake_thread,
  input  logic                 exc_req_en,
  input  threadid_t            exc_req_thread,
  input  exc_cause_t           exc_req_cause,
  output logic [N_THREADS-1:0] stalled,
  output logic                 exc_en,
  output threadid_t            exc_thread,
  output exc_cause_t           exc_cause
);

  localparam int              IW      = $clog2(N_THREADS);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(STALL_TIMEOUT - 1);
  localparam logic [TO_W-1:0] WD_MAX  = {TO_W{1'b1}};

  thread_state_t   state_q [N_THREADS];
  thread_state_t   state_d [N_THREADS];
  logic [TO_W-1:0] wd_q    [N_THREADS];
  logic [TO_W-1:0] wd_d    [N_THREADS];
  exc_cause_t      cause_q [N_THREADS];
  exc_cause_t      cause_d [N_THREADS];

  logic [IW-1:0]        rr_ptr_q;
  logic [N_THREADS-1:0] pend_vec;
  logic [N_THREADS-1:0] wake_hit;
  logic [N_THREADS-1:0] stall_hit;
  logic [N_THREADS-1:0] req_hit;
  logic [N_THREADS-1:0] grant_hit;
  logic [N_THREADS-1:0] stalled_d;
  logic                 grant_valid;
  logic [IW-1:0]        grant_idx;

  always_comb begin
    pend_vec  = '0;
    wake_hit  = '0;
    stall_hit = '0;
    req_hit   = '0;
    grant_hit = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      pend_vec[i]  = (state_q[i] == EXC_PEND);
      wake_hit[i]  = wake_en    && (wake_thread    == threadid_t'(i));
      stall_hit[i] = stall_en   && (stall_thread   == threadid_t'(i));
      req_hit[i]   = exc_req_en && (exc_req_thread == threadid_t'(i));
      grant_hit[i] = grant_valid && (grant_idx == IW'(i));
    end
  end

  rr_arbiter #(
    .N (N_THREADS),
    .IW(IW)
  ) u_rr_arbiter (
    .req  (pend_vec),
    .ptr  (rr_ptr_q),
    .valid(grant_valid),
    .idx  (grant_idx)
  );

  // Event priority per thread: wake, stall, timeout, grant, then exc_req.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      state_d[i]   = state_q[i];
      wd_d[i]      = wd_q[i];
      cause_d[i]   = cause_q[i];
      stalled_d[i] = 1'b0;

      case (state_q[i])
        RUN: begin
          if (stall_hit[i]) begin
            state_d[i] = STALL;
            wd_d[i]    = '0;
          end
        end
        STALL: begin
          if (wake_hit[i] && stall_hit[i]) begin
            wd_d[i] = '0;
          end else if (wake_hit[i]) begin
            state_d[i] = RUN;
          end else if (wd_q[i] == WD_LAST) begin
            state_d[i] = EXC_PEND;
            cause_d[i] = EXC_TIMEOUT;
          end else if (wd_q[i] != WD_MAX) begin
            wd_d[i] = wd_q[i] + TO_W'(1);
          end
        end
        EXC_PEND: begin
          if (grant_hit[i]) begin
            state_d[i] = RUN;
          end
        end
        default: state_d[i] = RUN;
      endcase

      // A still-pending exception keeps its original cause; a granted one re-pends.
      if (req_hit[i] && (state_d[i] != EXC_PEND)) begin
        state_d[i] = EXC_PEND;
        cause_d[i] = exc_req_cause;
      end

      stalled_d[i] = (state_d[i] != RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        state_q[i] <= RUN;
        wd_q[i]    <= '0;
        cause_q[i] <= EXC_NONE;
      end
      rr_ptr_q   <= IW'(N_THREADS - 1);
      stalled    <= '0;
      exc_en     <= 1'b0;
      exc_thread <= '0;
      exc_cause  <= EXC_NONE;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        state_q[i] <= state_d[i];
        wd_q[i]    <= wd_d[i];
        cause_q[i] <= cause_d[i];
      end
      stalled <= stalled_d;
      exc_en  <= grant_valid;
      if (grant_valid) begin
        exc_thread <= threadid_t'(grant_idx);
        exc_cause  <= cause_q[grant_idx];
        rr_ptr_q   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_thread_status_tracker.sv
// tb/tb_thread_status_tracker.sv - self-checking bench for thread_status_tracker
module tb_thread_status_tracker;
  import thread_status_tracker_pkg::*;

  localparam int N  = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_en, wake_en, exc_req_en;
  threadid_t  stall_thread, wake_thread, exc_req_thread;
  exc_cause_t exc_req_cause;
  logic [N-1:0] stalled;
  logic       exc_en;
  threadid_t  exc_thread;
  exc_cause_t exc_cause;

  always #5 clk = ~clk;

  thread_status_tracker #(.N_THREADS(N), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .stall_en(stall_en), .stall_thread(stall_thread),
    .wake_en(wake_en), .wake_thread(wake_thread),
    .exc_req_en(exc_req_en), .exc_req_thread(exc_req_thread), .exc_req_cause(exc_req_cause),
    .stalled(stalled), .exc_en(exc_en), .exc_thread(exc_thread), .exc_cause(exc_cause)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: 0=running, 1=stalled, 2=exception pending.
  int         mst[N];
  int         mstart[N];
  exc_cause_t mc[N];
  int         mptr;
  int         m_en, m_thr;
  exc_cause_t m_cause;
  int         edge_n = 0;

  task automatic model_step();
    int g, s, idx;
    exc_cause_t gc;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        mst[i] = 0; mstart[i] = 0; mc[i] = EXC_NONE;
      end
      mptr = N - 1; m_en = 0; m_thr = 0; m_cause = EXC_NONE;
    end else begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && mst[idx] == 2) g = idx;
      end
      gc = (g >= 0) ? mc[g] : EXC_NONE;
      for (int i = 0; i < N; i++) begin
        s = mst[i];
        if (s == 1) begin
          if (wake_en && int'(wake_thread) == i && stall_en && int'(stall_thread) == i)
            mstart[i] = edge_n;
          else if (wake_en && int'(wake_thread) == i)
            s = 0;
          else if (edge_n - mstart[i] == TO) begin
            s = 2; mc[i] = EXC_TIMEOUT;
          end
        end else if (s == 0 && stall_en && int'(stall_thread) == i) begin
          s = 1; mstart[i] = edge_n;
        end
        if (i == g) s = 0;
        if (exc_req_en && int'(exc_req_thread) == i && s != 2) begin
          s = 2; mc[i] = exc_req_cause;
        end
        mst[i] = s;
      end
      if (g >= 0) begin
        m_en = 1; m_thr = g; m_cause = gc; mptr = g;
      end else begin
        m_en = 0;
      end
    end
    edge_n++;
  endtask

  task automatic model_compare();
    int es;
    es = 0;
    for (int i = 0; i < N; i++) if (mst[i] != 0) es |= (1 << i);
    chk("model_stalled", int'(stalled), es);
    chk("model_exc_en", int'(exc_en), m_en);
    chk("model_exc_thread", int'(exc_thread), m_thr);
    chk("model_exc_cause", int'(exc_cause), int'(m_cause));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_compare();
  endtask

  task automatic drive(input logic se, input int st, input logic we, input int wt,
                       input logic xe, input int xt, input exc_cause_t xc);
    stall_en = se; stall_thread = threadid_t'(st);
    wake_en = we;  wake_thread = threadid_t'(wt);
    exc_req_en = xe; exc_req_thread = threadid_t'(xt); exc_req_cause = xc;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, EXC_NONE);
  endtask

  typedef struct {
    logic se; int st; logic we; int wt; logic xe; int xt; exc_cause_t xc;
    int es; int een; int et; exc_cause_t ec;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic se, input int st, input logic we, input int wt,
                              input logic xe, input int xt, input exc_cause_t xc,
                              input int es, input int een, input int et, input exc_cause_t ec);
    vec_t v;
    v.se = se; v.st = st; v.we = we; v.wt = wt; v.xe = xe; v.xt = xt; v.xc = xc;
    v.es = es; v.een = een; v.et = et; v.ec = ec;
    return v;
  endfunction

  int n;
  logic seen;

  initial begin
    tbl[0]  = mk(1, 3, 0, 0, 0, 0, EXC_NONE,    8'h08, 0, 0, EXC_NONE);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, EXC_NONE,    8'h08, 0, 0, EXC_NONE);
    tbl[2]  = mk(1, 5, 0, 0, 0, 0, EXC_NONE,    8'h28, 0, 0, EXC_NONE);
    tbl[3]  = mk(1, 5, 1, 5, 0, 0, EXC_NONE,    8'h28, 0, 0, EXC_NONE);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, EXC_NONE,    8'h28, 0, 0, EXC_NONE);
    tbl[5]  = mk(0, 0, 1, 3, 0, 0, EXC_NONE,    8'h20, 0, 0, EXC_NONE);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, EXC_ILLEGAL, 8'h21, 0, 0, EXC_NONE);
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, EXC_MEM,     8'h21, 1, 0, EXC_ILLEGAL);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, EXC_NONE,    8'h20, 1, 0, EXC_MEM);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, EXC_NONE,    8'h20, 0, 0, EXC_MEM);
    tbl[10] = mk(0, 0, 1, 5, 0, 0, EXC_NONE,    8'h00, 0, 0, EXC_MEM);
    tbl[11] = mk(0, 0, 0, 0, 1, 2, EXC_ILLEGAL, 8'h04, 0, 0, EXC_MEM);
    tbl[12] = mk(0, 0, 0, 0, 1, 3, EXC_MEM,     8'h08, 1, 2, EXC_ILLEGAL);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, EXC_NONE,    8'h00, 1, 3, EXC_MEM);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, EXC_NONE,    8'h00, 0, 3, EXC_MEM);

    rst = 1'b0;
    idle();
    tick();
    tick();
    chk("reset_stalled", int'(stalled), 0);
    chk("reset_exc_en", int'(exc_en), 0);
    chk("reset_exc_thread", int'(exc_thread), 0);
    chk("reset_exc_cause", int'(exc_cause), int'(EXC_NONE));
    rst = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (exc_en) seen = 1'b1;
      chk("idle_stalled", int'(stalled), 0);
      chk("idle_exc_thread", int'(exc_thread), 0);
    end
    chk("idle_no_exc", int'(seen), 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].se, tbl[i].st, tbl[i].we, tbl[i].wt, tbl[i].xe, tbl[i].xt, tbl[i].xc);
      tick();
      chk($sformatf("tbl%0d_stalled", i), int'(stalled), tbl[i].es);
      chk($sformatf("tbl%0d_exc_en", i), int'(exc_en), tbl[i].een);
      chk($sformatf("tbl%0d_exc_thread", i), int'(exc_thread), tbl[i].et);
      chk($sformatf("tbl%0d_exc_cause", i), int'(exc_cause), int'(tbl[i].ec));
    end

    // Watchdog timeout on thread 2
    drive(1, 2, 0, 0, 0, 0, EXC_NONE);
    tick();
    idle();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (exc_en) seen = 1'b1;
      else chk("to_stalled2_held", int'(stalled[2]), 1);
    end
    chk("to_seen", int'(seen), 1);
    chk("to_latency", n, TO + 1);
    chk("to_thread", int'(exc_thread), 2);
    chk("to_cause", int'(exc_cause), int'(EXC_TIMEOUT));
    tick();
    chk("to_single_pulse", int'(exc_en), 0);
    chk("to_stalled2_clear", int'(stalled[2]), 0);

    // Round-robin order 6,1,4 with rr_ptr=4
    drive(0, 0, 0, 0, 1, 4, EXC_ILLEGAL);
    tick();
    idle();
    tick();
    chk("rr_setup_thread", int'(exc_thread), 4);
    drive(1, 1, 0, 0, 0, 0, EXC_NONE);
    tick();
    idle();
    for (int i = 0; i < TO - 1; i++) tick();
    drive(0, 0, 0, 0, 1, 6, EXC_MEM);
    tick();
    chk("rr_pending", int'(stalled), 8'h42);
    drive(0, 0, 0, 0, 1, 4, EXC_ILLEGAL);
    tick();
    idle();
    chk("rr_g1_en", int'(exc_en), 1);
    chk("rr_g1_thread", int'(exc_thread), 6);
    chk("rr_g1_cause", int'(exc_cause), int'(EXC_MEM));
    tick();
    chk("rr_g2_en", int'(exc_en), 1);
    chk("rr_g2_thread", int'(exc_thread), 1);
    chk("rr_g2_cause", int'(exc_cause), int'(EXC_TIMEOUT));
    tick();
    chk("rr_g3_en", int'(exc_en), 1);
    chk("rr_g3_thread", int'(exc_thread), 4);
    chk("rr_g3_cause", int'(exc_cause), int'(EXC_ILLEGAL));
    tick();
    chk("rr_done", int'(exc_en), 0);

    // Reset while threads 2 and 7 are pending
    drive(1, 7, 0, 0, 0, 0, EXC_NONE);
    tick();
    idle();
    for (int i = 0; i < TO - 1; i++) tick();
    drive(0, 0, 0, 0, 1, 2, EXC_MEM);
    tick();
    chk("rst_pending", int'(stalled), 8'h84);
    idle();
    rst = 1'b0;
    tick();
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_exc_en", int'(exc_en), 0);
    chk("rst_exc_thread", int'(exc_thread), 0);
    chk("rst_exc_cause", int'(exc_cause), int'(EXC_NONE));
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (exc_en) seen = 1'b1;
    end
    chk("rst_no_stale_grant", int'(seen), 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) != 0);
      drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, N - 1)),
            exc_cause_t'($urandom_range(1, 3)));
      tick();
    end
    rst = 1'b1;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
